// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control/status bundle for the programmable clock divider
interface clk_div_gen_if #(
    parameter int DIV_W = 8
) ();
    logic             enable;
    logic [DIV_W-1:0] div;
    logic             div_req;
    logic             div_ack;
    logic             clk_out;
    logic             rise_pulse;
    logic             busy;

    modport master (
        output enable,
        output div,
        output div_req,
        input  div_ack,
        input  clk_out,
        input  rise_pulse,
        input  busy
    );

    modport slave (
        input  enable,
        input  div,
        input  div_req,
        output div_ack,
        output clk_out,
        output rise_pulse,
        output busy
    );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - glitch-free programmable integer clock divider with ratio handshake
module clk_div_gen #(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_gen_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             div_ack_q, div_ack_d;
    logic             busy_q, busy_d;
    logic             period_start;

    // Phase sequencing: each half-period lasts active+1 cycles; a new period
    // may only begin at the end of a low phase (or from idle), so no runts.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_start = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.enable) begin
                    state_d      = HIGH;
                    period_start = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == active_q) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == active_q) begin
                    cnt_d = '0;
                    if (bus.enable) begin
                        state_d      = HIGH;
                        period_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ratio handshake: the already-pending ratio is applied on a period start;
    // a request landing on that same edge stays pending for the next period.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        div_ack_d       = 1'b0;
        if (period_start && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
            div_ack_d       = 1'b1;
        end
        if (bus.div_req) begin
            pending_d       = bus.div;
            pending_valid_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so clk_out and rise_pulse
    // rise together in the first cycle of the high phase.
    always_comb begin
        clk_out_d    = (state_d == HIGH);
        rise_pulse_d = period_start;
        busy_d       = (state_d != IDLE);
    end

    // State and output registers; reset forces clk_out low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            active_q        <= DIV_W'(DIV_RESET);
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            clk_out_q       <= 1'b0;
            rise_pulse_q    <= 1'b0;
            div_ack_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            clk_out_q       <= clk_out_d;
            rise_pulse_q    <= rise_pulse_d;
            div_ack_q       <= div_ack_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.clk_out    = clk_out_q;
    assign bus.rise_pulse = rise_pulse_q;
    assign bus.div_ack    = div_ack_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - scoreboard bench for clk_div_gen
module tb_clk_div_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_div_gen_if #(.DIV_W(8)) bus ();

    clk_div_gen #(.DIV_W(8), .DIV_RESET(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int hi;
        int lo;
        bit ack;
    } period_t;

    period_t exp_q[$];
    int      checks     = 0;
    int      passes     = 0;
    int      timeouts   = 0;
    bit      done       = 1'b0;
    bit      final_done = 1'b0;

    task automatic push(input int hi, input int lo, input bit ack);
        period_t p;
        p.hi  = hi;
        p.lo  = lo;
        p.ack = ack;
        exp_q.push_back(p);
    endtask

    task automatic wait_rise();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rise_pulse && n < 200);
        if (!bus.rise_pulse) timeouts++;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 200);
        if (bus.busy) timeouts++;
        repeat (4) @(negedge clk);
    endtask

    task automatic request(input logic [7:0] v);
        bus.div     = v;
        bus.div_req = 1'b1;
        @(negedge clk);
        bus.div_req = 1'b0;
    endtask

    // Stimulus: directed scenarios; expected periods pushed as they are planned.
    initial begin
        int n;
        bus.enable  = 1'b0;
        bus.div     = '0;
        bus.div_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Default ratio: 2 high / 2 low, three periods.
        push(2, 2, 0); push(2, 2, 0); push(2, 2, 0);
        bus.enable = 1'b1;
        repeat (3) wait_rise();
        bus.enable = 1'b0;
        wait_idle();

        // div=0 loaded while idle, applied on the first rise.
        push(1, 1, 1); push(1, 1, 0); push(1, 1, 0);
        request(8'd0);
        bus.enable = 1'b1;
        repeat (3) wait_rise();
        bus.enable = 1'b0;
        wait_idle();

        // Running at div=3, request div=1 in mid-high of the second period.
        push(4, 4, 1); push(4, 4, 0); push(2, 2, 1); push(2, 2, 0);
        request(8'd3);
        bus.enable = 1'b1;
        repeat (2) wait_rise();
        @(negedge clk);
        request(8'd1);
        repeat (2) wait_rise();
        bus.enable = 1'b0;
        wait_idle();

        // Two requests in one period: last one wins, single ack.
        push(2, 2, 0); push(3, 3, 1); push(3, 3, 0);
        bus.enable = 1'b1;
        wait_rise();
        bus.div     = 8'd5;
        bus.div_req = 1'b1;
        @(negedge clk);
        bus.div     = 8'd2;
        @(negedge clk);
        bus.div_req = 1'b0;
        repeat (2) wait_rise();
        bus.enable = 1'b0;
        wait_idle();

        // Enable drops on the second high cycle: the full period still completes.
        push(4, 4, 1);
        request(8'd3);
        bus.enable = 1'b1;
        wait_rise();
        @(negedge clk);
        bus.enable = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        // Reset mid-high with a request pending: restart at the reset ratio, no ack.
        push(2, 2, 0); push(2, 2, 0);
        bus.enable = 1'b1;
        wait_rise();
        request(8'd0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) wait_rise();
        bus.enable = 1'b0;
        wait_idle();

        done = 1'b1;
        n = 0;
        while (!final_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Monitor: measures each period from rise_pulse and checks it against the queue.
    initial begin : monitor
        bit measuring = 1'b0;
        bit prev_clk  = 1'b0;
        bit ack_seen  = 1'b0;
        int hi = 0;
        int lo = 0;
        period_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                checks++;
                if (bus.clk_out == 1'b0 && bus.busy == 1'b0 &&
                    bus.rise_pulse == 1'b0 && bus.div_ack == 1'b0)
                    passes++;
                else
                    $display("FAIL reset_outputs: got clk_out=%0b busy=%0b rise=%0b ack=%0b, expected all 0",
                             bus.clk_out, bus.busy, bus.rise_pulse, bus.div_ack);
                measuring = 1'b0;
                prev_clk  = 1'b0;
            end else begin
                if (bus.div_ack && !bus.rise_pulse) begin
                    checks++;
                    $display("FAIL ack_alignment: got div_ack=1 with rise_pulse=0, expected ack only on a rise");
                end
                if (bus.rise_pulse || (bus.clk_out && !prev_clk)) begin
                    checks++;
                    if (bus.rise_pulse == (bus.clk_out && !prev_clk))
                        passes++;
                    else
                        $display("FAIL rise_alignment: got rise_pulse=%0b clk_out=%0b prev=%0b, expected pulse exactly on first high cycle",
                                 bus.rise_pulse, bus.clk_out, prev_clk);
                end
                if (bus.rise_pulse || (measuring && !bus.busy)) begin
                    if (measuring) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL unexpected_period: got hi=%0d lo=%0d ack=%0b, expected no period", hi, lo, ack_seen);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.hi == hi && e.lo == lo && e.ack == ack_seen)
                                passes++;
                            else
                                $display("FAIL period_shape: got hi=%0d lo=%0d ack=%0b, expected hi=%0d lo=%0d ack=%0b",
                                         hi, lo, ack_seen, e.hi, e.lo, e.ack);
                        end
                    end
                    measuring = bus.rise_pulse;
                    hi        = 0;
                    lo        = 0;
                    ack_seen  = bus.div_ack;
                end
                if (measuring) begin
                    if (bus.clk_out) hi++;
                    else             lo++;
                end
                prev_clk = bus.clk_out;
                if (done && !final_done) begin
                    checks++;
                    if (exp_q.size() == 0 && timeouts == 0)
                        passes++;
                    else
                        $display("FAIL end_state: got %0d unmatched periods and %0d timeouts, expected 0 and 0",
                                 exp_q.size(), timeouts);
                    final_done = 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
Programmable integer clock divider producing a registered, glitch-free divided clock `clk_out` from the single system clock. It sits directly upstream of the clock-output black-box stage and supplies that stage's clock-producing path. Divide ratio changes use a req/ack handshake and take effect only at period boundaries. Start and stop are glitch-free: no runt high or low phases.

Parameters:
DIV_W, 8, width of divide-ratio field.
DIV_RESET, 1, active half-period ratio after reset; must be < 2**DIV_W.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  run request; level-sensitive.
div  input  DIV_W  requested half-period minus one; sampled with div_req.
div_req  input  1  one-cycle request to load div.
div_ack  output  1  one-cycle pulse when the pending ratio becomes active.
clk_out  output  1  divided clock, registered.
rise_pulse  output  1  one-cycle pulse in the first cycle `clk_out` is high each period.
busy  output  1  high when not in IDLE.

Behaviour:
- Reset is asynchronous assert, synchronous release. Reset values:
  - Outputs: clk_out=0, rise_pulse=0, div_ack=0, busy=0.
  - State: FSM=IDLE, cnt=0, active=DIV_RESET, pending_valid=0.
- Half-period length is active+1 clk cycles, so period = 2*(active+1).
  - active=0 gives clk/2.
  - Max active gives clk/(2**(DIV_W+1)).
- FSM states:
  - IDLE: clk_out=0, cnt held 0.
    - If enable is sampled 1 at edge N, go to HIGH at edge N.
    - clk_out=1 and rise_pulse=1 are visible in the cycle after edge N.
  - HIGH: clk_out=1. cnt increments each cycle.
    - When cnt==active, go to LOW next edge and clear cnt.
    - Enable is ignored in HIGH, so the high phase always completes.
  - LOW: clk_out=0. cnt increments each cycle.
    - When cnt==active and enable=1, go to HIGH, clear cnt, pulse rise_pulse.
    - When cnt==active and enable=0, go to IDLE.
- Ratio handshake:
  - div_req=1 captures div into pending and sets pending_valid.
  - A later req before apply overwrites pending (last wins).
  - Pending is applied at a period start, i.e. on the same edge that enters HIGH from LOW or IDLE.
    - On that edge: active<=pending, pending_valid<=0, div_ack=1 for one cycle.
    - The new active governs the HIGH phase that starts on that edge.
  - If div_req coincides with an apply edge, the newly captured value stays pending for the next period. The value already pending is applied.
  - In IDLE, pending is applied on the edge that leaves IDLE. No ack occurs while idle.
- cnt is DIV_W bits and never wraps, because it is cleared at cnt==active.
- busy=1 in HIGH and LOW, and 0 in IDLE.
- Reset mid-operation: clk_out drops immediately (asynchronous) and pending is discarded.
- rise_pulse and clk_out are both registered and rise in the same cycle.

Test Plan:
1. Reset; enable=1 with default DIV_RESET=1 -> clk_out goes 1 the cycle after enable is seen, then 2 high / 2 low repeating. rise_pulse appears every 4 cycles. busy=1.
2. div=0 with div_req in IDLE, then enable -> div_ack pulses with the first rise; clk_out toggles every cycle (period 2).
3. Running at div=3 (4 high / 4 low); issue div_req with div=1 mid-high-phase -> the current period completes as 4/4. div_ack fires at the next rise, then 2/2 periods follow.
4. Two div_req (div=5, then div=2) in one period -> only 2 is applied; a single div_ack; next period is 3 high / 3 low.
5. enable drops on the 2nd high cycle with div=3 -> high completes (4 cycles), low completes (4 cycles), then IDLE. busy falls and there is no further rise_pulse.
6. rst_n asserted mid-high with a request pending -> clk_out=0 asynchronously; after release active=DIV_RESET, no div_ack, and the restart period is 2 high / 2 low.
